// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-port controller for the 2R1W core register file.
//
// The single RF write port is shared between the pipeline writeback stage
// and out-of-order remote load responses. Writeback always wins. Remote
// responses wait in a small FIFO and drain whenever writeback is idle. A
// per-register scoreboard tracks outstanding remote loads for issue-stage
// hazard checks. A starvation guard asks the pipeline to yield the port
// when buffered responses keep losing to writeback.
//
// Optional feature macro: RF_WB_ARB_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty and
//   writeback is idle is written to the RF in the same cycle, without
//   passing through the FIFO.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   wb_v_i, wb_addr_i, wb_data_i     pipeline writeback request
//   rsp_v_i, rsp_addr_i, rsp_data_i  remote load response
//   rsp_ready_o                      FIFO can accept a response
//   issue_v_i, issue_addr_i          remote load issued (marks pending)
//   rs_addr_i, rd_addr_i             issue-stage registers under hazard check
//   hazard_o                         either checked register is pending
//   wb_stall_o                       pipeline must hold wb_v_i low
//   rf_wen_o, rf_waddr_o, rf_wdata_o register file write port
//   fifo_empty_o                     no buffered responses
module rf_wb_arbiter #(
  parameter int addr_width_p   = 5,
  parameter int fifo_els_p     = 4,
  parameter int starve_limit_p = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wb_v_i,
  input  logic [addr_width_p-1:0] wb_addr_i,
  input  logic [31:0]             wb_data_i,
  input  logic                    rsp_v_i,
  input  logic [addr_width_p-1:0] rsp_addr_i,
  input  logic [31:0]             rsp_data_i,
  output logic                    rsp_ready_o,
  input  logic                    issue_v_i,
  input  logic [addr_width_p-1:0] issue_addr_i,
  input  logic [addr_width_p-1:0] rs_addr_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    hazard_o,
  output logic                    wb_stall_o,
  output logic                    rf_wen_o,
  output logic [addr_width_p-1:0] rf_waddr_o,
  output logic [31:0]             rf_wdata_o,
  output logic                    fifo_empty_o
);

  localparam int regs_lp     = 1 << addr_width_p;
  localparam int ptr_w_lp    = $clog2(fifo_els_p);
  localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0]    full_cnt_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  // Payload storage is not reset; only pointers/count qualify it.
  logic [addr_width_p-1:0] fifo_addr [fifo_els_p];
  logic [31:0]             fifo_data [fifo_els_p];
  logic [ptr_w_lp-1:0]     rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0]     count;
  logic [regs_lp-1:0]      sb, sb_next;
  logic [starve_w_lp-1:0]  starve_cnt, starve_next;
  logic                    stall_r, stall_next;

  logic                    bypass, pop, push, set_v, clear_v;
  logic                    sel_v;
  logic [addr_width_p-1:0] sel_addr, clear_addr;
  logic [31:0]             sel_data;

  assign rsp_ready_o  = (count != full_cnt_lp);
  assign fifo_empty_o = (count == '0);
  assign hazard_o     = sb[rs_addr_i] | sb[rd_addr_i];
  assign wb_stall_o   = stall_r;

`ifdef RF_WB_ARB_BYPASS_EN
  assign bypass = reset_n & fifo_empty_o & ~wb_v_i & rsp_v_i;
`else
  assign bypass = 1'b0;
`endif

  // Nothing moves in a reset cycle: no pop, no push, no RF write.
  assign pop   = reset_n & ~wb_v_i & ~fifo_empty_o;
  assign push  = reset_n & rsp_v_i & rsp_ready_o & ~bypass;
  assign set_v = issue_v_i & (issue_addr_i != '0);

  // Write-port source select: writeback, then FIFO head, then bypass.
  always_comb begin
    sel_v    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (wb_v_i) begin
      sel_v    = 1'b1;
      sel_addr = wb_addr_i;
      sel_data = wb_data_i;
    end else if (!fifo_empty_o) begin
      sel_v    = 1'b1;
      sel_addr = fifo_addr[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (bypass) begin
      sel_v    = 1'b1;
      sel_addr = rsp_addr_i;
      sel_data = rsp_data_i;
    end
  end

  // x0 is never written; an x0 FIFO entry is still consumed.
  assign rf_wen_o   = reset_n & sel_v & (sel_addr != '0);
  assign rf_waddr_o = rf_wen_o ? sel_addr : '0;
  assign rf_wdata_o = rf_wen_o ? sel_data : '0;

  assign clear_v    = pop | bypass;
  assign clear_addr = pop ? fifo_addr[rd_ptr] : rsp_addr_i;

  // Scoreboard: clear applied first so a same-address set wins.
  always_comb begin
    sb_next = sb;
    if (clear_v) sb_next[clear_addr] = 1'b0;
    if (set_v)   sb_next[issue_addr_i] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Starvation counter counts consecutive losses of a non-empty FIFO.
  always_comb begin
    starve_next = starve_cnt;
    if (pop) begin
      starve_next = '0;
    end else if (!fifo_empty_o && wb_v_i && (starve_cnt != starve_max_lp)) begin
      starve_next = starve_cnt + 1'b1;
    end
    stall_next = !pop && (stall_r || (starve_next == starve_max_lp));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      sb         <= '0;
      starve_cnt <= '0;
      stall_r    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count + cnt_w_lp'(push) - cnt_w_lp'(pop);
      sb         <= sb_next;
      starve_cnt <= starve_next;
      stall_r    <= stall_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= rsp_addr_i;
      fifo_data[wr_ptr] <= rsp_data_i;
    end
  end

  // Protocol checks on the surrounding pipeline.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(set_v && sb[issue_addr_i]))
        else $error("rf_wb_arbiter: issue to already-pending register %0d", issue_addr_i);
      assert (!(wb_v_i && stall_r))
        else $error("rf_wb_arbiter: writeback asserted while stalled");
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based
// reference model.
module tb_rf_wb_arbiter;

  localparam int AW  = 5;
  localparam int N   = 4;
  localparam int LIM = 8;
`ifdef RF_WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_v_i;
  logic [AW-1:0] wb_addr_i;
  logic [31:0]   wb_data_i;
  logic          rsp_v_i;
  logic [AW-1:0] rsp_addr_i;
  logic [31:0]   rsp_data_i;
  logic          rsp_ready_o;
  logic          issue_v_i;
  logic [AW-1:0] issue_addr_i;
  logic [AW-1:0] rs_addr_i;
  logic [AW-1:0] rd_addr_i;
  logic          hazard_o;
  logic          wb_stall_o;
  logic          rf_wen_o;
  logic [AW-1:0] rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic          fifo_empty_o;

  rf_wb_arbiter #(.addr_width_p(AW), .fifo_els_p(N), .starve_limit_p(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rsp_v_i(rsp_v_i), .rsp_addr_i(rsp_addr_i), .rsp_data_i(rsp_data_i),
    .rsp_ready_o(rsp_ready_o),
    .issue_v_i(issue_v_i), .issue_addr_i(issue_addr_i),
    .rs_addr_i(rs_addr_i), .rd_addr_i(rd_addr_i), .hazard_o(hazard_o),
    .wb_stall_o(wb_stall_o),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fifo_empty_o(fifo_empty_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { logic [AW-1:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit   pend [32];
  int   starve;
  bit   stall_m;
  bit   last_accept;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    starve  = 0;
    stall_m = 1'b0;
  endtask

  // Called with inputs already driven at a negedge: compares every output
  // against the model, advances the model across the next posedge, and
  // returns at the following negedge.
  task automatic step();
    bit          ready_m, nonempty, popm, byp, wv, wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    ent_t        e;
    #1;
    ready_m  = (q.size() < N);
    nonempty = (q.size() > 0);
    chk("rsp_ready", rsp_ready_o, ready_m);
    chk("fifo_empty", fifo_empty_o, !nonempty);
    chk("hazard", hazard_o, pend[rs_addr_i] | pend[rd_addr_i]);
    chk("wb_stall", wb_stall_o, stall_m);
    wv = 0; wa = '0; wd = '0; popm = 0; byp = 0;
    if (reset_n) begin
      if (wb_v_i) begin
        wv = 1; wa = wb_addr_i; wd = wb_data_i;
      end else if (nonempty) begin
        wv = 1; wa = q[0].a; wd = q[0].d; popm = 1;
      end else if (BYP && rsp_v_i) begin
        wv = 1; wa = rsp_addr_i; wd = rsp_data_i; byp = 1;
      end
    end
    wen = wv && (wa != 0);
    chk("rf_wen", rf_wen_o, wen);
    chk("rf_waddr", rf_waddr_o, wen ? wa : 5'd0);
    chk("rf_wdata", rf_wdata_o, wen ? wd : 32'd0);
    last_accept = reset_n && rsp_v_i && (byp || ready_m);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (popm) void'(q.pop_front());
      if (rsp_v_i && ready_m && !byp) begin
        e.a = rsp_addr_i; e.d = rsp_data_i;
        q.push_back(e);
      end
      if (popm || byp) pend[wa] = 1'b0;
      if (issue_v_i && issue_addr_i != 0) pend[issue_addr_i] = 1'b1;
      if (popm) begin
        starve = 0; stall_m = 1'b0;
      end else if (nonempty && wb_v_i) begin
        if (starve < LIM) starve++;
        if (starve == LIM) stall_m = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_v_i = 0; wb_addr_i = '0; wb_data_i = '0;
    rsp_v_i = 0; rsp_addr_i = '0; rsp_data_i = '0;
    issue_v_i = 0; issue_addr_i = '0; rs_addr_i = '0; rd_addr_i = '0;
  endtask

  bit            h_v;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_data;
  logic [AW-1:0] outst[$];
  int            drain;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    step();                       // reset cycle, checked against model
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ready", rsp_ready_o, 1);
      chk("idle_empty", fifo_empty_o, 1);
      chk("idle_hazard", hazard_o, 0);
      chk("idle_wen", rf_wen_o, 0);
      step();
    end

    // Issue x5, hazard, response returns
    issue_v_i = 1; issue_addr_i = 5; step();
    issue_v_i = 0; rs_addr_i = 5;
    #1; chk("x5_hazard_set", hazard_o, 1); step();
    rsp_v_i = 1; rsp_addr_i = 5; rsp_data_i = 32'hDEADBEEF;
    #1;
    if (BYP) begin
      chk("x5_byp_wen", rf_wen_o, 1);
      chk("x5_byp_waddr", rf_waddr_o, 5);
      chk("x5_byp_wdata", rf_wdata_o, 32'hDEADBEEF);
    end
    step();
    rsp_v_i = 0;
    #1;
    if (!BYP) begin
      chk("x5_wen", rf_wen_o, 1);
      chk("x5_waddr", rf_waddr_o, 5);
      chk("x5_wdata", rf_wdata_o, 32'hDEADBEEF);
      chk("x5_hazard_hold", hazard_o, 1);
    end else begin
      chk("x5_hazard_clr_byp", hazard_o, 0);
    end
    step();
    #1; chk("x5_hazard_clr", hazard_o, 0); step();
    rs_addr_i = 0;

    // Collision: writeback x3 while response x7 arrives
    wb_v_i = 1; wb_addr_i = 3; wb_data_i = 32'h11;
    rsp_v_i = 1; rsp_addr_i = 7; rsp_data_i = 32'h22;
    #1;
    chk("col_wb_waddr", rf_waddr_o, 3);
    chk("col_wb_wdata", rf_wdata_o, 32'h11);
    step();
    idle_inputs();
    #1;
    chk("col_rsp_wen", rf_wen_o, 1);
    chk("col_rsp_waddr", rf_waddr_o, 7);
    chk("col_rsp_wdata", rf_wdata_o, 32'h22);
    step();
    #1; chk("col_empty", fifo_empty_o, 1); step();

    // Fill the FIFO under continuous writeback, then starvation
    for (int c = 1; c <= 11; c++) begin
      wb_v_i = (c <= 9); wb_addr_i = 1; wb_data_i = 32'(c);
      rsp_v_i = 1;
      rsp_addr_i = AW'(9 + ((c < 5) ? c : 5));
      rsp_data_i = 32'hA0 + 32'(9 + ((c < 5) ? c : 5));
      #1;
      if (c == 5)  chk("fill_ready_low", rsp_ready_o, 0);
      if (c == 9)  chk("starve_not_yet", wb_stall_o, 0);
      if (c == 10) begin
        chk("starve_stall", wb_stall_o, 1);
        chk("starve_pop_addr", rf_waddr_o, 10);
        chk("starve_pop_data", rf_wdata_o, 32'hAA);
      end
      if (c == 11) chk("starve_release", wb_stall_o, 0);
      step();
    end
    idle_inputs();
    drain = 0;
    while (!fifo_empty_o && drain < 20) begin
      step();
      drain++;
    end
    chk("drain_bounded", (drain < 20), 1);

    // x0 writes from both sources
    wb_v_i = 1; wb_addr_i = 0; wb_data_i = 32'h55;
    rsp_v_i = 1; rsp_addr_i = 0; rsp_data_i = 32'h66;
    #1;
    chk("x0_wb_wen", rf_wen_o, 0);
    chk("x0_wb_waddr", rf_waddr_o, 0);
    step();
    idle_inputs();
    #1;
    chk("x0_rsp_wen", rf_wen_o, 0);
    chk("x0_rsp_queued", fifo_empty_o, 0);
    step();
    #1;
    chk("x0_popped", fifo_empty_o, 1);
    chk("x0_no_hazard", hazard_o, 0);
    step();

    // Randomized phase
    h_v = 0; h_addr = '0; h_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        idle_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        h_v = 0;
        outst.delete();
      end
      wb_v_i    = !stall_m && ($urandom_range(0, 99) < 55);
      wb_addr_i = AW'($urandom_range(0, 31));
      wb_data_i = $urandom();
      if (!h_v) begin
        if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
          int idx;
          idx    = $urandom_range(0, outst.size() - 1);
          h_v    = 1;
          h_addr = outst[idx];
          h_data = $urandom();
          outst.delete(idx);
        end else if ($urandom_range(0, 31) == 0) begin
          h_v = 1; h_addr = '0; h_data = $urandom();
        end
      end
      rsp_v_i = h_v; rsp_addr_i = h_addr; rsp_data_i = h_data;
      issue_v_i = 0; issue_addr_i = '0;
      if ($urandom_range(0, 99) < 30) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(1, 31));
        if (!pend[a]) begin
          issue_v_i = 1; issue_addr_i = a;
          outst.push_back(a);
        end
      end
      rs_addr_i = AW'($urandom_range(0, 31));
      rd_addr_i = AW'($urandom_range(0, 31));
      step();
      if (h_v && last_accept) h_v = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
